stream_mux_nto1: RTL and testbench
==================================

STREAM_MUX_NTO1 -- requirements
Module: stream_mux_nto1

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width per channel.
REQ-002 SHALL have parameter N_CH, default 4, input channel count (legal range 2..16).
REQ-003 SHALL have parameter SEL_WIDTH, default $clog2(N_CH), select and channel-ID width.
REQ-004 SHALL have one clock and a synchronous, active-high reset, ports named clk and rst.
REQ-005 Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_data  in  N_CH*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
- in_valid  in  N_CH  per-channel valid
- in_ready  out  N_CH  per-channel ready
- rr_mode  in  1  1 = round-robin arbitration, 0 = explicit select
- sel  in  SEL_WIDTH  channel select when rr_mode = 0
- out_data  out  WIDTH  registered data
- out_ch  out  SEL_WIDTH  source channel of out_data
- out_valid  out  1  output valid
- out_ready  in  1  downstream ready

Function
REQ-006 SHALL register the output: a beat accepted in cycle t appears on out_data/out_ch/out_valid in cycle t+1.
REQ-007 SHALL treat the output stage as free when (!out_valid || out_ready).
REQ-008 SHALL assert in_ready[i] only for the granted channel i, and only while the output stage is free; all other bits SHALL be 0.
REQ-009 SHALL accept a beat when in_valid[g] && in_ready[g]; out_data/out_ch SHALL then load in_data[g] and g, and out_valid SHALL be set.
REQ-010 SHALL clear out_valid when out_valid && out_ready and no beat is accepted in the same cycle; simultaneous drain and accept SHALL keep out_valid at 1.
REQ-011 SHALL hold out_data/out_ch/out_valid stable while out_valid && !out_ready.
REQ-012 With rr_mode = 0, SHALL grant g = sel; if sel >= N_CH, no channel SHALL be granted.
REQ-013 With rr_mode = 1, SHALL grant the first channel with in_valid set, searching from priority pointer ptr upward modulo N_CH.
REQ-014 After each accepted beat in round-robin mode from channel k, ptr SHALL become (k+1) mod N_CH; otherwise ptr SHALL hold.
REQ-015 SHALL compute in_ready combinationally from current valid, sel, rr_mode and output-stage state; it SHALL have no combinational path from in_data.
REQ-016 Changing rr_mode or sel while no lock is held SHALL take effect on the same cycle.

Reset
REQ-017 On rst: out_valid = 0, out_data = 0, out_ch = 0, ptr = 0, lock state = UNLOCKED; in_ready SHALL be all-0 during rst.
REQ-018 Reset SHALL discard any beat held in the output register; no beat SHALL be presented after reset deasserts.

Configuration
REQ-019 Macro STREAM_MUX_PKT_LOCK_EN, when defined, SHALL add ports in_last (in, N_CH) and out_last (out, 1, registered alongside out_data).
REQ-020 With STREAM_MUX_PKT_LOCK_EN, the FSM SHALL have two states:
- UNLOCKED -> LOCKED on an accepted beat with in_last[g] = 0, latching g.
- LOCKED grants only the latched channel, ignoring sel, rr_mode and ptr.
- LOCKED -> UNLOCKED on an accepted beat with in_last = 1.
REQ-021 Without STREAM_MUX_PKT_LOCK_EN, SHALL re-arbitrate every cycle, with no last ports and no FSM.

Structure
REQ-022 Shared package stream_mux_pkg SHALL hold the lock-state enum (UNLOCKED, LOCKED) and the default WIDTH/N_CH constants.
REQ-023 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req, ptr; outputs grant_valid, grant_idx).

Verification
REQ-024 rst high 2 cycles, then in_valid = 4'b1111 -> out_valid = 0 during reset; first output out_ch = 0.
REQ-025 rr_mode = 1, all valid, out_ready = 1 -> out_ch sequence 0,1,2,3,0, one beat per cycle, latency 1.
REQ-026 rr_mode = 0, sel = 2, data2 = 16'hBEEF, out_ready = 0 for 3 cycles -> out_data = 16'hBEEF held stable, in_ready = 0 while stalled.
REQ-027 rr_mode = 1, in_valid = 4'b1010, ptr = 0 -> grants 1, 3, 1, 3.
REQ-028 STREAM_MUX_PKT_LOCK_EN defined: channel 1 sends a 3-beat packet while channel 0 is valid -> 3 consecutive out_ch = 1, out_last on the third beat, then channel 0 is granted.
REQ-029 rst asserted mid-packet with out_valid = 1 -> next cycle out_valid = 0 and state UNLOCKED; the new packet starts on any channel.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared definitions for the N-to-1 stream multiplexer.
// The lock-state enum is only used when STREAM_MUX_PKT_LOCK_EN is defined.
package stream_mux_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_N_CH  = 4;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    // Next channel index after idx, wrapping at n.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request picker: returns the first asserted request at or after
// the priority pointer, wrapping modulo N.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    int cand;

    // Walk offsets 0..N-1 from ptr; the first live request wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int i = 0; i < N; i++) begin
            cand = int'(ptr) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            for (int j = 0; j < N; j++) begin
                if (!grant_valid && (j == cand) && req[j]) begin
                    grant_valid = 1'b1;
                    grant_idx   = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/stream_mux_nto1.sv
// N-to-1 valid/ready stream multiplexer with a registered output stage,
// explicit-select or round-robin arbitration; STREAM_MUX_PKT_LOCK_EN adds packet locking.
module stream_mux_nto1
    import stream_mux_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int N_CH      = DEFAULT_N_CH,
    parameter int SEL_WIDTH = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH*WIDTH-1:0]  in_data,
    input  logic [N_CH-1:0]        in_valid,
    output logic [N_CH-1:0]        in_ready,
    input  logic                   rr_mode,
    input  logic [SEL_WIDTH-1:0]   sel,
    output logic [WIDTH-1:0]       out_data,
    output logic [SEL_WIDTH-1:0]   out_ch,
    output logic                   out_valid,
    input  logic                   out_ready
`ifdef STREAM_MUX_PKT_LOCK_EN
    ,
    input  logic [N_CH-1:0]        in_last,
    output logic                   out_last
`endif
);

    logic [SEL_WIDTH-1:0]      ptr_q;
    logic [SEL_WIDTH-1:0]      ptr_next;
    logic [SEL_WIDTH-1:0]      rr_idx;
    logic                      rr_valid;
    logic [SEL_WIDTH-1:0]      grant_idx;
    logic                      grant_valid;
    logic [WIDTH-1:0]          grant_data;
    logic                      grant_in_valid;
    logic                      stage_free;
    logic                      accept;
    logic [2**SEL_WIDTH-1:0]   sel_ok;

    // Select values at or beyond N_CH name no channel and grant nothing.
    for (genvar i = 0; i < 2**SEL_WIDTH; i++) begin : g_sel_ok
        assign sel_ok[i] = (i < N_CH);
    end

    rr_arbiter #(
        .N     (N_CH),
        .IDX_W (SEL_WIDTH)
    ) u_rr_arbiter (
        .req         (in_valid),
        .ptr         (ptr_q),
        .grant_valid (rr_valid),
        .grant_idx   (rr_idx)
    );

`ifdef STREAM_MUX_PKT_LOCK_EN
    lock_state_t          state_q;
    lock_state_t          state_d;
    logic [SEL_WIDTH-1:0] lock_ch_q;
    logic [SEL_WIDTH-1:0] lock_ch_d;
    logic                 grant_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= UNLOCKED;
            lock_ch_q <= '0;
        end else begin
            state_q   <= state_d;
            lock_ch_q <= lock_ch_d;
        end
    end

    // A non-final beat pins the grant to its channel until that channel's last beat.
    always_comb begin
        state_d   = state_q;
        lock_ch_d = lock_ch_q;
        case (state_q)
            UNLOCKED: begin
                if (accept && !grant_last) begin
                    state_d   = LOCKED;
                    lock_ch_d = grant_idx;
                end
            end
            LOCKED: begin
                if (accept && grant_last) begin
                    state_d = UNLOCKED;
                end
            end
            default: state_d = UNLOCKED;
        endcase
    end
`endif

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
        if (state_q == LOCKED) begin
            grant_valid = 1'b1;
            grant_idx   = lock_ch_q;
        end else
`endif
        if (rr_mode) begin
            grant_valid = rr_valid;
            grant_idx   = rr_idx;
        end else begin
            grant_valid = sel_ok[sel];
            grant_idx   = sel;
        end
    end

    // Per-channel mux of the granted channel; in_ready never looks at in_data.
    always_comb begin
        grant_data     = '0;
        grant_in_valid = 1'b0;
`ifdef STREAM_MUX_PKT_LOCK_EN
        grant_last     = 1'b0;
`endif
        for (int i = 0; i < N_CH; i++) begin
            if (grant_idx == SEL_WIDTH'(i)) begin
                grant_data     = in_data[i*WIDTH +: WIDTH];
                grant_in_valid = in_valid[i];
`ifdef STREAM_MUX_PKT_LOCK_EN
                grant_last     = in_last[i];
`endif
            end
        end
    end

    assign stage_free = !out_valid || out_ready;
    assign accept     = !rst && grant_valid && stage_free && grant_in_valid;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N_CH; i++) begin
            in_ready[i] = !rst && grant_valid && stage_free &&
                          (grant_idx == SEL_WIDTH'(i));
        end
    end

    always_comb begin
        ptr_next = ptr_q;
        if (accept && rr_mode) begin
            ptr_next = SEL_WIDTH'(wrap_inc(int'(grant_idx), N_CH));
        end
    end

    // Output register: load on accept, drain on out_ready, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr_q     <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_ch    <= grant_idx;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            ptr_q <= ptr_next;
        end
    end

`ifdef STREAM_MUX_PKT_LOCK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            out_last <= 1'b0;
        end else if (accept) begin
            out_last <= grant_last;
        end
    end
`endif

endmodule

// File: tb/tb_stream_mux_nto1.sv
// Scoreboard bench for stream_mux_nto1; covers the packet-lock path when
// STREAM_MUX_PKT_LOCK_EN is defined.
module tb_stream_mux_nto1;

    localparam int WIDTH = 16;
    localparam int N_CH  = 4;
`ifdef STREAM_MUX_PKT_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [1:0]       ch;
        logic             last;
    } beat_t;

    logic                  clk;
    logic                  rst;
    logic [N_CH*WIDTH-1:0] inData;
    logic [N_CH-1:0]       inValid;
    logic [N_CH-1:0]       inReady;
    logic                  rrMode;
    logic [1:0]            sel;
    logic [WIDTH-1:0]      outData;
    logic [1:0]            outCh;
    logic                  outValid;
    logic                  outReady;
    logic [N_CH-1:0]       lastIn;
    logic                  outLast;

    int    checkCount = 0;
    int    passCount  = 0;
    beat_t sb[$];
    int    obsCh[$];
    int    obsLast[$];

    logic  mValid  = 1'b0;
    int    mPtr    = 0;
    logic  mLocked = 1'b0;
    int    mLockCh = 0;

    stream_mux_nto1 #(
        .WIDTH     (WIDTH),
        .N_CH      (N_CH),
        .SEL_WIDTH (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (inData),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .rr_mode   (rrMode),
        .sel       (sel),
        .out_data  (outData),
        .out_ch    (outCh),
        .out_valid (outValid),
        .out_ready (outReady)
`ifdef STREAM_MUX_PKT_LOCK_EN
        ,
        .in_last   (lastIn),
        .out_last  (outLast)
`endif
    );

`ifndef STREAM_MUX_PKT_LOCK_EN
    assign outLast = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end else begin
            passCount++;
        end
    endtask

    task automatic applyStimulus(input logic [N_CH-1:0] valid, input logic rr, input logic [1:0] s,
                                 input logic ordy, input logic [N_CH-1:0] last);
        inValid  = valid;
        rrMode   = rr;
        sel      = s;
        outReady = ordy;
        lastIn   = last;
    endtask

    // One clock: check DUT against the model at the falling edge, then advance the model.
    task automatic tick();
        logic            free;
        logic            gv;
        logic            acc;
        int              g;
        logic [N_CH-1:0] expReady;
        beat_t           b;
        @(negedge clk);
        free = !mValid || outReady;
        gv   = 1'b0;
        g    = 0;
        if (LOCK_EN && mLocked) begin
            gv = 1'b1;
            g  = mLockCh;
        end else if (rrMode) begin
            for (int i = 0; i < N_CH; i++) begin
                if (!gv && inValid[(mPtr + i) % N_CH]) begin
                    gv = 1'b1;
                    g  = (mPtr + i) % N_CH;
                end
            end
        end else begin
            gv = (int'(sel) < N_CH);
            g  = int'(sel);
        end
        expReady = (!rst && gv && free) ? N_CH'(1 << g) : '0;
        checkOutput("in_ready", 32'(inReady), 32'(expReady));
        acc = expReady[g] && inValid[g];
        if (!rst) begin
            checkOutput("out_valid", 32'(outValid), 32'(mValid));
            if (mValid) begin
                checkOutput("sb_size", 32'(sb.size()), 32'd1);
                if (sb.size() > 0) begin
                    checkOutput("out_data", 32'(outData), 32'(sb[0].data));
                    checkOutput("out_ch", 32'(outCh), 32'(sb[0].ch));
                    if (LOCK_EN) begin
                        checkOutput("out_last", 32'(outLast), 32'(sb[0].last));
                    end
                    if (outReady) begin
                        obsCh.push_back(int'(outCh));
                        obsLast.push_back(int'(outLast));
                        void'(sb.pop_front());
                    end
                end
            end
        end
        if (acc) begin
            b.data = inData[g*WIDTH +: WIDTH];
            b.ch   = 2'(g);
            b.last = lastIn[g];
            sb.push_back(b);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            mValid  = 1'b0;
            mPtr    = 0;
            mLocked = 1'b0;
            sb.delete();
        end else if (acc) begin
            mValid = 1'b1;
            if (rrMode) mPtr = (g + 1) % N_CH;
            if (LOCK_EN) begin
                if (!mLocked && !lastIn[g]) begin
                    mLocked = 1'b1;
                    mLockCh = g;
                end else if (mLocked && lastIn[g]) begin
                    mLocked = 1'b0;
                end
            end
        end else if (outReady) begin
            mValid = 1'b0;
        end
    endtask

    task automatic setData(input int ch, input logic [WIDTH-1:0] d);
        inData[ch*WIDTH +: WIDTH] = d;
    endtask

    initial begin
        int expSeq0[5] = '{0, 1, 2, 3, 0};
        int expSeq1[4] = '{1, 3, 1, 3};
        int expLock[4] = '{1, 1, 1, 0};
        int expLast[4] = '{0, 0, 1, 0};

        rst = 1'b1;
        for (int i = 0; i < N_CH; i++) setData(i, WIDTH'(16'h1000 * (i + 1) + i));
        applyStimulus(4'b1111, 1'b1, 2'd0, 1'b1, 4'b0000);
        tick();
        tick();
        checkOutput("rst_out_valid", 32'(outValid), 32'd0);
        checkOutput("rst_in_ready", 32'(inReady), 32'd0);

        // Round-robin, every channel valid: 0,1,2,3,0 back to back.
        rst = 1'b0;
        obsCh.delete();
        for (int i = 0; i < 6; i++) tick();
        checkOutput("rr_seq_len", 32'(obsCh.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < obsCh.size()) checkOutput("rr_seq", 32'(obsCh[i]), 32'(expSeq0[i]));
        end

        // Sparse round-robin from ptr 0: channels 1 and 3 alternate.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(4'b1010, 1'b1, 2'd0, 1'b1, 4'b0000);
        obsCh.delete();
        for (int i = 0; i < 5; i++) tick();
        for (int i = 0; i < 4; i++) begin
            if (i < obsCh.size()) checkOutput("rr_sparse", 32'(obsCh[i]), 32'(expSeq1[i]));
        end
        checkOutput("rr_sparse_len", 32'(obsCh.size()), 32'd4);

        // Explicit select with a stalled sink: BEEF must stay put.
        applyStimulus(4'b0000, 1'b0, 2'd2, 1'b1, 4'b0000);
        tick();
        tick();
        setData(2, 16'hBEEF);
        applyStimulus(4'b0100, 1'b0, 2'd2, 1'b0, 4'b0000);
        tick();
        setData(2, 16'h1234);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("stall_data", 32'(outData), 32'h0000BEEF);
            checkOutput("stall_ready", 32'(inReady), 32'd0);
        end
        outReady = 1'b1;
        tick();
        tick();

`ifdef STREAM_MUX_PKT_LOCK_EN
        // Channel 1 packet of three beats holds the grant against channel 0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        setData(0, 16'h0A0A);
        setData(1, 16'h1B1B);
        applyStimulus(4'b0011, 1'b0, 2'd1, 1'b1, 4'b0000);
        obsCh.delete();
        obsLast.delete();
        tick();
        sel = 2'd0;
        tick();
        lastIn = 4'b0010;
        tick();
        lastIn = 4'b0000;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i < obsCh.size()) begin
                checkOutput("lock_ch", 32'(obsCh[i]), 32'(expLock[i]));
                checkOutput("lock_last", 32'(obsLast[i]), 32'(expLast[i]));
            end
        end
`endif

        // Reset in the middle of a packet with a beat held in the output.
        applyStimulus(4'b0010, 1'b0, 2'd1, 1'b0, 4'b0000);
        tick();
        checkOutput("pre_rst_valid", 32'(outValid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("post_rst_valid", 32'(outValid), 32'd0);
        applyStimulus(4'b0001, 1'b0, 2'd0, 1'b1, 4'b0000);
        #1;
        checkOutput("post_rst_ready", 32'(inReady), 32'd1);
        tick();
        tick();

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < N_CH; c++) setData(c, WIDTH'($urandom));
            inValid  = N_CH'($urandom);
            outReady = ($urandom_range(0, 3) != 0);
            sel      = 2'($urandom);
            lastIn   = N_CH'($urandom);
            if ($urandom_range(0, 7) == 0) rrMode = ~rrMode;
            tick();
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
